// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 8;
  localparam int unsigned FIFO_DEF_DEPTH = 16;
  localparam int unsigned FIFO_STD       = 0;
  localparam int unsigned FIFO_FWFT      = 1;

  function automatic int unsigned fifo_clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x != 0) begin
      x = x >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sync_fifo_param_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEF_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_en_i,
  input  logic [fifo_clog2(DEPTH)-1:0]  wr_addr_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  input  logic                          rd_en_i,
  input  logic [fifo_clog2(DEPTH)-1:0]  rd_addr_i,
  output logic [WIDTH-1:0]              rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read of the address being written returns the old word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, programmable flags and optional FWFT read.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned WIDTH    = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = FIFO_STD
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic                        full_o,
  output logic                        almost_full_o,
  output logic                        wr_error_o,
  input  logic                        rd_en_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        empty_o,
  output logic                        almost_empty_o,
  output logic                        rd_error_o,
  output logic [fifo_clog2(DEPTH):0]  count_o
);

  localparam int unsigned ADDR_W  = fifo_clog2(DEPTH);
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, ram_used;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic             head_sel_q, head_sel_d;
  logic [WIDTH-1:0] byp_q, byp_d, ram_rdata;
  logic             rd_accept, wr_accept, head_free, ram_empty;
  logic             bypass, ram_wr, ram_rd;

  // In FWFT mode the head word lives outside the RAM: either in the bypass
  // register (write into an empty FIFO) or in the RAM read register (refill).
  always_comb begin
    rd_accept  = rd_en_i && !empty_q;
    wr_accept  = wr_en_i && (!full_q || rd_accept);
    ram_used   = wr_ptr_q - rd_ptr_q;
    ram_empty  = (ram_used == '0);
    head_free  = empty_q || rd_accept;
    bypass     = IS_FWFT && wr_accept && head_free && ram_empty;
    ram_wr     = wr_accept && !bypass;
    ram_rd     = !ram_empty && (IS_FWFT ? head_free : rd_accept);

    wr_ptr_d   = wr_ptr_q + CNT_W'(ram_wr);
    rd_ptr_d   = rd_ptr_q + CNT_W'(ram_rd);
    count_d    = count_q + CNT_W'(wr_accept) - CNT_W'(rd_accept);

    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    af_d       = (count_d >= CNT_W'(AF_LEVEL));
    ae_d       = (count_d <= CNT_W'(AE_LEVEL));
    wr_err_d   = wr_en_i && !wr_accept;
    rd_err_d   = rd_en_i && !rd_accept;

    head_sel_d = head_sel_q;
    byp_d      = byp_q;
    if (ram_rd) begin
      head_sel_d = 1'b1;
    end else if (bypass) begin
      head_sel_d = 1'b0;
    end
    if (bypass) begin
      byp_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      head_sel_q <= 1'b0;
      byp_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
      head_sel_q <= head_sel_d;
      byp_q      <= byp_d;
    end
  end

  sync_fifo_param_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (ram_wr),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (wdata_i),
    .rd_en_i   (ram_rd),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (ram_rdata)
  );

  assign rdata_o        = (IS_FWFT && !head_sel_q) ? byp_q : ram_rdata;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: standard and FWFT instances against queue-based reference models.
module tb_sync_fifo_param;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_s, rd_s, wr_f, rd_f;
  logic [7:0] wd_s, wd_f;
  logic       full_s, af_s, werr_s, empty_s, ae_s, rerr_s;
  logic       full_f, af_f, werr_f, empty_f, ae_f, rerr_f;
  logic [7:0] rdata_s, rdata_f;
  logic [4:0] count_s, count_f;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic [7:0] m_rdata_s;
  logic       m_werr_s, m_rerr_s, m_werr_f, m_rerr_f;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_s), .wdata_i(wd_s), .full_o(full_s),
    .almost_full_o(af_s), .wr_error_o(werr_s), .rd_en_i(rd_s), .rdata_o(rdata_s),
    .empty_o(empty_s), .almost_empty_o(ae_s), .rd_error_o(rerr_s), .count_o(count_s)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_f), .wdata_i(wd_f), .full_o(full_f),
    .almost_full_o(af_f), .wr_error_o(werr_f), .rd_en_i(rd_f), .rdata_o(rdata_f),
    .empty_o(empty_f), .almost_empty_o(ae_f), .rd_error_o(rerr_f), .count_o(count_f)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue; a read pops the oldest entry, a write
  // succeeds if there is room or a pop frees room in the same cycle.
  task automatic model_step();
    bit rok, wok;
    if (!rst_n) begin
      q_s.delete(); q_f.delete();
      m_rdata_s = 8'h00;
      m_werr_s = 1'b0; m_rerr_s = 1'b0; m_werr_f = 1'b0; m_rerr_f = 1'b0;
    end else begin
      rok = rd_s && (q_s.size() > 0);
      wok = wr_s && ((q_s.size() < DEPTH) || rok);
      m_werr_s = wr_s && !wok;
      m_rerr_s = rd_s && !rok;
      if (rok) m_rdata_s = q_s.pop_front();
      if (wok) q_s.push_back(wd_s);
      rok = rd_f && (q_f.size() > 0);
      wok = wr_f && ((q_f.size() < DEPTH) || rok);
      m_werr_f = wr_f && !wok;
      m_rerr_f = rd_f && !rok;
      if (rok) void'(q_f.pop_front());
      if (wok) q_f.push_back(wd_f);
    end
  endtask

  task automatic check_all();
    int ns, nf;
    ns = q_s.size();
    nf = q_f.size();
    chk("s_count",  32'(count_s), 32'(ns));
    chk("s_full",   32'(full_s),  32'(ns == DEPTH));
    chk("s_empty",  32'(empty_s), 32'(ns == 0));
    chk("s_af",     32'(af_s),    32'(ns >= 14));
    chk("s_ae",     32'(ae_s),    32'(ns <= 2));
    chk("s_werr",   32'(werr_s),  32'(m_werr_s));
    chk("s_rerr",   32'(rerr_s),  32'(m_rerr_s));
    chk("s_rdata",  32'(rdata_s), 32'(m_rdata_s));
    chk("f_count",  32'(count_f), 32'(nf));
    chk("f_full",   32'(full_f),  32'(nf == DEPTH));
    chk("f_empty",  32'(empty_f), 32'(nf == 0));
    chk("f_af",     32'(af_f),    32'(nf >= 14));
    chk("f_ae",     32'(ae_f),    32'(nf <= 2));
    chk("f_werr",   32'(werr_f),  32'(m_werr_f));
    chk("f_rerr",   32'(rerr_f),  32'(m_rerr_f));
    if (nf > 0) chk("f_rdata", 32'(rdata_f), 32'(q_f[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wr_s = 1'b0; rd_s = 1'b0; wd_s = 8'h00;
    wr_f = 1'b0; rd_f = 1'b0; wd_f = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic std_op(input logic w, input logic r, input logic [7:0] d);
    wr_s = w; rd_s = r; wd_s = d;
    tick();
    wr_s = 1'b0; rd_s = 1'b0;
  endtask

  task automatic fwft_op(input logic w, input logic r, input logic [7:0] d);
    wr_f = w; rd_f = r; wd_f = d;
    tick();
    wr_f = 1'b0; rd_f = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic       werr;
    logic       rerr;
    logic [7:0] rdat;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h11};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 1'b1, 8'h22, 1, 1'b0, 1'b1, 8'h11};
    tbl[4] = '{1'b1, 1'b0, 8'h33, 2, 1'b0, 1'b0, 8'h11};
    tbl[5] = '{1'b1, 1'b1, 8'h44, 2, 1'b0, 1'b0, 8'h22};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h33};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h44};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h44};

    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_empty", 32'(empty_s), 32'd1);
    chk("rst_ae",    32'(ae_s),    32'd1);
    chk("rst_full",  32'(full_s),  32'd0);
    chk("rst_count", 32'(count_s), 32'd0);
    chk("rst_rdata", 32'(rdata_s), 32'd0);
    rst_n = 1'b1;

    // Directed vector table on the standard-mode instance
    for (int i = 0; i < 9; i++) begin
      std_op(tbl[i].wr, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), 32'(count_s), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_werr", i),  32'(werr_s),  32'(tbl[i].werr));
      chk($sformatf("tbl%0d_rerr", i),  32'(rerr_s),  32'(tbl[i].rerr));
      chk($sformatf("tbl%0d_rdata", i), 32'(rdata_s), 32'(tbl[i].rdat));
    end

    // Fill to full and overflow
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      std_op(1'b1, 1'b0, 8'(i));
      chk("fill_af",   32'(af_s),   32'(i >= 14));
      chk("fill_full", 32'(full_s), 32'(i == 16));
    end
    std_op(1'b1, 1'b0, 8'hEE);
    chk("ovf_werr",  32'(werr_s),  32'd1);
    chk("ovf_count", 32'(count_s), 32'd16);
    tick();
    chk("ovf_pulse", 32'(werr_s),  32'd0);

    // Drain in order and underflow
    for (int i = 1; i <= 16; i++) begin
      std_op(1'b0, 1'b1, 8'h00);
      chk("drain_rdata", 32'(rdata_s), 32'(i));
    end
    chk("drain_empty", 32'(empty_s), 32'd1);
    std_op(1'b0, 1'b1, 8'h00);
    chk("udf_rerr",  32'(rerr_s),  32'd1);
    chk("udf_rdata", 32'(rdata_s), 32'h10);

    // Simultaneous write and read at full
    for (int i = 1; i <= 16; i++) std_op(1'b1, 1'b0, 8'(8'h20 + i));
    std_op(1'b1, 1'b1, 8'hAA);
    chk("fullrw_count", 32'(count_s), 32'd16);
    chk("fullrw_full",  32'(full_s),  32'd1);
    chk("fullrw_werr",  32'(werr_s),  32'd0);
    chk("fullrw_rdata", 32'(rdata_s), 32'h21);
    for (int i = 0; i < 16; i++) std_op(1'b0, 1'b1, 8'h00);
    chk("fullrw_last", 32'(rdata_s), 32'hAA);

    // Simultaneous write and read at empty
    std_op(1'b1, 1'b1, 8'h55);
    chk("emptyrw_rerr",  32'(rerr_s),  32'd1);
    chk("emptyrw_count", 32'(count_s), 32'd1);
    std_op(1'b0, 1'b1, 8'h00);
    chk("emptyrw_rdata", 32'(rdata_s), 32'h55);

    // Pointer wrap: interleaved write/read pairs with random data
    for (int i = 0; i < 40; i++) begin
      std_op(1'b1, 1'b0, 8'($urandom));
      std_op(1'b0, 1'b1, 8'h00);
    end

    // Random mixed traffic, biased to reach both boundaries
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      std_op(1'(($urandom % 100) < wp), 1'(($urandom % 100) < (100 - wp)), 8'($urandom));
      chk("rand_bound", 32'(count_s <= 5'd16), 32'd1);
      if (i == 217) do_reset();
    end

    // FWFT: write into empty visible on the next cycle without a read
    do_reset();
    fwft_op(1'b1, 1'b0, 8'h33);
    chk("fwft_rdata", 32'(rdata_f), 32'h33);
    chk("fwft_empty", 32'(empty_f), 32'd0);
    tick();
    chk("fwft_hold",  32'(rdata_f), 32'h33);
    fwft_op(1'b0, 1'b1, 8'h00);
    chk("fwft_pop_empty", 32'(empty_f), 32'd1);

    // FWFT random traffic
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 70 : 30;
      fwft_op(1'(($urandom % 100) < wp), 1'(($urandom % 100) < (100 - wp)), 8'($urandom));
    end

    // FWFT full with simultaneous write and read
    do_reset();
    for (int i = 1; i <= 16; i++) fwft_op(1'b1, 1'b0, 8'(8'h40 + i));
    chk("fwft_full_head", 32'(rdata_f), 32'h41);
    fwft_op(1'b1, 1'b1, 8'hBB);
    chk("fwft_fullrw_count", 32'(count_f), 32'd16);
    chk("fwft_fullrw_head",  32'(rdata_f), 32'h42);
    chk("fwft_fullrw_werr",  32'(werr_f),  32'd0);
    for (int i = 0; i < 15; i++) fwft_op(1'b0, 1'b1, 8'h00);
    chk("fwft_last_head", 32'(rdata_f), 32'hBB);

    // FWFT reset with count 5; requests in the reset cycle are ignored
    do_reset();
    for (int i = 0; i < 5; i++) fwft_op(1'b1, 1'b0, 8'(8'h60 + i));
    chk("fwft_pre_rst_count", 32'(count_f), 32'd5);
    rst_n = 1'b0; wr_f = 1'b1; rd_f = 1'b1; wd_f = 8'h77;
    tick();
    chk("fwft_rst_count", 32'(count_f), 32'd0);
    chk("fwft_rst_empty", 32'(empty_f), 32'd1);
    chk("fwft_rst_werr",  32'(werr_f),  32'd0);
    chk("fwft_rst_rerr",  32'(rerr_f),  32'd0);
    rst_n = 1'b1; wr_f = 1'b0; rd_f = 1'b0;
    tick();
    chk("fwft_post_rst_count", 32'(count_f), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
